trace_capture_buf: RTL and testbench

//  Downstream observer stage that sits beside the DUT in tbench_top and consumes its output bus.

---
 rtl/trace_capture_buf.sv | 196 +++++++++++++++++++
 tb/tb_trace_capture_buf.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buf.sv
// trace_capture_buf
//   Logic-analyzer stage that records qualified samples of a DUT output bus
//   into a circular buffer. Arm to start pre-trigger recording. A qualified
//   trigger starts a programmable post-trigger window. The retained window is
//   then drained oldest-first over a valid/ready read port.
//
// State table
//   state  | meaning
//   IDLE   | waiting for arm; count/wrapped show last capture
//   PRE    | recording pre-trigger samples, waiting for trig&sample_en
//   POST   | recording post-trigger samples until remaining hits 0
//   DUMP   | draining retained entries oldest-first
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   arm, post_cnt         start capture / post-trigger length (latched on arm)
//   sample_en, sample_data, trig   sample stream and trigger
//   state, count, wrapped status
//   rd_valid, rd_data, rd_last, rd_ready   drain port
module trace_capture_buf #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W:0]   post_cnt,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trig,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              wrapped,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DUMP = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wrapped_q, wrapped_d;
  logic [ADDR_W:0]     post_q, post_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  // entries not yet loaded into the output register
  logic [ADDR_W:0]     left_q, left_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;
  logic                mem_we;
  logic                enter_dump;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    post_d     = post_q;
    remain_d   = remain_q;
    left_d     = left_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    mem_we     = 1'b0;
    enter_dump = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_PRE;
          wr_ptr_d  = '0;
          count_d   = '0;
          wrapped_d = 1'b0;
          if (post_cnt == '0)
            post_d = ONE_C;
          else if (post_cnt > DEPTH_C)
            post_d = DEPTH_C;
          else
            post_d = post_cnt;
        end
      end

      S_PRE, S_POST: begin
        if (sample_en) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_A;
          if (count_q == DEPTH_C)
            wrapped_d = 1'b1;
          else
            count_d = count_q + ONE_C;

          if (state_q == S_PRE) begin
            if (trig) begin
              if (post_q == ONE_C) begin
                enter_dump = 1'b1;
              end else begin
                state_d  = S_POST;
                remain_d = post_q - ONE_C;
              end
            end
          end else begin
            remain_d = remain_q - ONE_C;
            if (remain_q == ONE_C)
              enter_dump = 1'b1;
          end
        end
      end

      S_DUMP: begin
        // Output register doubles as prefetch: reload on the same edge as
        // a handshake so a continuously-ready consumer sees no bubbles.
        if (!rd_valid_q || rd_ready) begin
          if (left_q != '0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_last_d  = (left_q == ONE_C);
            rd_ptr_d   = rd_ptr_q + ONE_A;
            left_d     = left_q - ONE_C;
          end else begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (enter_dump) begin
      state_d  = S_DUMP;
      // count==DEPTH truncates to 0, so the oldest entry is at wr_ptr
      rd_ptr_d = wr_ptr_d - count_d[ADDR_W-1:0];
      left_d   = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      post_q     <= ONE_C;
      remain_q   <= '0;
      left_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      post_q     <= post_d;
      remain_q   <= remain_d;
      left_q     <= left_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Buffer storage is not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem_q[wr_ptr_q] <= sample_data;
  end

  assign state    = state_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_trace_capture_buf.sv
// Directed bench for trace_capture_buf (DEPTH=8): a small capture model
// queues expected entries as samples are driven; drained entries are popped
// and compared.
module tb_trace_capture_buf;
  localparam int DW = 32;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic [AW:0]   post_cnt = '0;
  logic          sample_en = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          trig = 1'b0;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          wrapped;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [1:0]    m_state = 2'd0;
  int            m_post = 1;
  int            m_rem = 0;
  int            m_count = 0;
  logic          m_wrapped = 1'b0;

  trace_capture_buf #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .arm(arm), .post_cnt(post_cnt),
    .sample_en(sample_en), .sample_data(sample_data), .trig(trig),
    .state(state), .count(count), .wrapped(wrapped),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_state"}, 64'(state), 64'(m_state));
    chk({tag, "_count"}, 64'(count), 64'(m_count));
    chk({tag, "_wrapped"}, 64'(wrapped), 64'(m_wrapped));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_state = 2'd0; m_count = 0; m_wrapped = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_arm(input int p, input logic noise);
    arm = 1'b1;
    post_cnt = (AW+1)'(p);
    sample_en = noise; trig = noise; sample_data = 32'hDEAD_BEEF;
    if (m_state == 2'd0) begin
      m_state = 2'd1; m_count = 0; m_wrapped = 1'b0;
      exp_q.delete();
      m_post = (p == 0) ? 1 : (p > DP ? DP : p);
    end
    step();
    arm = 1'b0; sample_en = 1'b0; trig = 1'b0;
    chk_status("arm");
  endtask

  task automatic sample(input logic [DW-1:0] d, input logic t);
    sample_en = 1'b1; sample_data = d; trig = t;
    if (m_state == 2'd1 || m_state == 2'd2) begin
      exp_q.push_back(d);
      if (exp_q.size() > DP) void'(exp_q.pop_front());
      if (m_count == DP) m_wrapped = 1'b1; else m_count++;
      if (m_state == 2'd1) begin
        if (t) begin
          if (m_post == 1) m_state = 2'd3;
          else begin m_state = 2'd2; m_rem = m_post - 1; end
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_state = 2'd3;
      end
    end
    step();
    sample_en = 1'b0; trig = 1'b0;
    chk_status("sample");
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating
  task automatic drain(input int mode, input bit from_entry);
    int cyc = 0;
    bit done = 0, stall = 0, seen = 0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    logic [DW-1:0] e;
    while (!done && cyc < 200) begin
      rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (from_entry && cyc == 0) chk("entry_valid_low", 64'(rd_valid), 64'd0);
      if (from_entry && cyc == 1) chk("entry_valid_high", 64'(rd_valid), 64'd1);
      if (mode == 0 && seen) chk("no_bubble", 64'(rd_valid), 64'd1);
      if (stall) begin
        chk("stall_data", 64'(rd_data), 64'(pd));
        chk("stall_last", 64'(rd_last), 64'(pl));
      end
      stall = rd_valid && !rd_ready;
      pd = rd_data; pl = rd_last;
      if (rd_valid) seen = 1;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_entry", 64'd1, 64'd0);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(e));
          chk("rd_last", 64'(rd_last), 64'(exp_q.size() == 0));
          if (exp_q.size() == 0) done = 1;
        end
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    m_state = 2'd0;
    chk_status("post_dump");
    chk("post_dump_valid", 64'(rd_valid), 64'd0);
  endtask

  task automatic t1_setup();
    do_arm(2, 1'b0);
    sample(32'hA0, 1'b0);
    sample(32'hA1, 1'b0);
    sample(32'hA2, 1'b1);
    sample(32'hA3, 1'b0);
  endtask

  initial begin
    step();
    do_reset();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_last", 64'(rd_last), 64'd0);

    // IDLE ignores trig/sample_en
    sample(32'h11, 1'b1);

    // T1 basic
    t1_setup();
    drain(0, 1'b1);

    // T2 wrap
    do_arm(2, 1'b0);
    for (int i = 0; i < 12; i++) sample(DW'(i), 1'b0);
    sample(32'd12, 1'b1);
    sample(32'd13, 1'b0);
    drain(0, 1'b1);

    // T3 backpressure
    t1_setup();
    drain(1, 1'b1);

    // T4 clamp and qualification; arm cycle carries trig&sample_en
    do_arm(0, 1'b1);
    sample_en = 1'b0; trig = 1'b1; sample_data = 32'h77;
    step();
    trig = 1'b0;
    chk_status("unqual_trig");
    sample(32'h55, 1'b1);
    drain(0, 1'b1);

    // T5 reset mid-POST
    do_arm(3, 1'b0);
    sample(32'hB0, 1'b1);
    sample(32'hB1, 1'b0);
    do_reset();
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_valid", 64'(rd_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    t1_setup();
    drain(0, 1'b1);

    // T6 arm during DUMP with stalled consumer
    t1_setup();
    arm = 1'b1; post_cnt = 4'd5; rd_ready = 1'b0;
    sample_en = 1'b1; trig = 1'b1; sample_data = 32'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_status("dump_arm");
    end
    arm = 1'b0; sample_en = 1'b0; trig = 1'b0;
    drain(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
